// File: rtl/rtc_bus_ctrl.sv
// Controller for the RTC multiplexed address/data bus: single or burst register reads/writes.
// Optional burst support is built when RTC_BURST_EN is defined (len honoured, address auto-increment).
module rtc_bus_ctrl #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 8,
    parameter int unsigned T_HOLD   = 2,
    parameter int unsigned T_GAP    = 4,
    parameter int unsigned MAX_LEN  = 16,
    localparam int unsigned LW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_rw,
    input  logic [7:0]    i_addr,
    input  logic [LW-1:0] i_len,
    input  logic [7:0]    i_wr_data,
    output logic          o_wr_ack,
    output logic [7:0]    o_rd_data,
    output logic          o_rd_valid,
    output logic          o_busy,
    output logic          o_done,
    inout  wire  [7:0]    io_dato,
    output logic          o_ad,
    output logic          o_cs,
    output logic          o_wr,
    output logic          o_rd
);

    localparam int unsigned T_MAX1 = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int unsigned T_MAX2 = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int unsigned T_MAX  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
    localparam int unsigned CW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SETUP,
        S_A_STROBE,
        S_A_HOLD,
        S_GAP,
        S_D_SETUP,
        S_D_STROBE,
        S_D_HOLD,
        S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]    r_addr, w_addr_nxt;
    logic          r_rw, w_rw_nxt;
    logic [7:0]    r_wdat, w_wdat_nxt;
    logic          r_gap_to_data, w_gap_to_data_nxt;
    logic [7:0]    r_rd_data, w_rd_data_nxt;
    logic          r_rd_valid, w_rd_valid_nxt;
    logic          r_wr_ack, w_wr_ack_nxt;
    logic          r_done, w_done_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_cs, w_cs_nxt;
    logic          r_wr, w_wr_nxt;
    logic          r_rd, w_rd_nxt;
    logic          r_ad, w_ad_nxt;
    logic          r_drv, w_drv_nxt;
    logic [7:0]    r_dout, w_dout_nxt;
    logic          w_more;

`ifdef RTC_BURST_EN
    logic [LW-1:0] r_rem, w_rem_nxt;
    assign w_more = (r_rem != '0);
`else
    logic w_unused_len;
    assign w_unused_len = ^i_len;
    assign w_more       = 1'b0;
`endif

    // Counter value loaded on entry to a timed state: holds cycles-remaining minus one.
    function automatic logic [CW-1:0] reload(input state_t s);
        case (s)
            S_A_SETUP, S_D_SETUP:   reload = CW'(T_SETUP - 1);
            S_A_STROBE, S_D_STROBE: reload = CW'(T_STROBE - 1);
            S_A_HOLD, S_D_HOLD:     reload = CW'(T_HOLD - 1);
            S_GAP:                  reload = CW'(T_GAP - 1);
            default:                reload = '0;
        endcase
    endfunction

    // Next state, datapath updates and one-cycle pulses.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_addr_nxt        = r_addr;
        w_rw_nxt          = r_rw;
        w_wdat_nxt        = r_wdat;
        w_gap_to_data_nxt = r_gap_to_data;
        w_rd_data_nxt     = r_rd_data;
        w_rd_valid_nxt    = 1'b0;
        w_wr_ack_nxt      = 1'b0;
        w_done_nxt        = 1'b0;
`ifdef RTC_BURST_EN
        w_rem_nxt         = r_rem;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_A_SETUP;
                    w_addr_nxt  = i_addr;
                    w_rw_nxt    = i_rw;
`ifdef RTC_BURST_EN
                    w_rem_nxt   = i_len;
`endif
                end
            end
            S_A_SETUP:  if (r_cnt == '0) w_state_nxt = S_A_STROBE;
            S_A_STROBE: if (r_cnt == '0) w_state_nxt = S_A_HOLD;
            S_A_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt       = S_GAP;
                    w_gap_to_data_nxt = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    if (r_gap_to_data) begin
                        w_state_nxt = S_D_SETUP;
                        if (!r_rw) begin
                            w_wdat_nxt   = i_wr_data;
                            w_wr_ack_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_A_SETUP;
                    end
                end
            end
            S_D_SETUP: if (r_cnt == '0) w_state_nxt = S_D_STROBE;
            S_D_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_D_HOLD;
                    if (r_rw) begin
                        w_rd_data_nxt  = io_dato;
                        w_rd_valid_nxt = 1'b1;
                    end
                end
            end
            S_D_HOLD: begin
                if (r_cnt == '0) begin
                    if (w_more) begin
                        w_state_nxt       = S_GAP;
                        w_gap_to_data_nxt = 1'b0;
                        w_addr_nxt        = r_addr + 8'd1;
`ifdef RTC_BURST_EN
                        w_rem_nxt         = r_rem - LW'(1);
`endif
                    end else begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = reload(w_state_nxt);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    // Pin values for the upcoming state, registered so the pins are glitch-free.
    always_comb begin
        w_cs_nxt   = 1'b1;
        w_wr_nxt   = 1'b1;
        w_rd_nxt   = 1'b1;
        w_ad_nxt   = 1'b1;
        w_drv_nxt  = 1'b0;
        w_dout_nxt = 8'h00;
        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        case (w_state_nxt)
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                w_cs_nxt   = 1'b0;
                w_ad_nxt   = 1'b0;
                w_drv_nxt  = 1'b1;
                w_dout_nxt = w_addr_nxt;
                w_wr_nxt   = (w_state_nxt != S_A_STROBE);
            end
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                w_cs_nxt = 1'b0;
                if (w_rw_nxt) begin
                    w_rd_nxt = (w_state_nxt != S_D_STROBE);
                end else begin
                    w_drv_nxt  = 1'b1;
                    w_dout_nxt = w_wdat_nxt;
                    w_wr_nxt   = (w_state_nxt != S_D_STROBE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_addr        <= 8'h00;
            r_rw          <= 1'b0;
            r_wdat        <= 8'h00;
            r_gap_to_data <= 1'b0;
            r_rd_data     <= 8'h00;
            r_rd_valid    <= 1'b0;
            r_wr_ack      <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_cs          <= 1'b1;
            r_wr          <= 1'b1;
            r_rd          <= 1'b1;
            r_ad          <= 1'b1;
            r_drv         <= 1'b0;
            r_dout        <= 8'h00;
`ifdef RTC_BURST_EN
            r_rem         <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_addr        <= w_addr_nxt;
            r_rw          <= w_rw_nxt;
            r_wdat        <= w_wdat_nxt;
            r_gap_to_data <= w_gap_to_data_nxt;
            r_rd_data     <= w_rd_data_nxt;
            r_rd_valid    <= w_rd_valid_nxt;
            r_wr_ack      <= w_wr_ack_nxt;
            r_done        <= w_done_nxt;
            r_busy        <= w_busy_nxt;
            r_cs          <= w_cs_nxt;
            r_wr          <= w_wr_nxt;
            r_rd          <= w_rd_nxt;
            r_ad          <= w_ad_nxt;
            r_drv         <= w_drv_nxt;
            r_dout        <= w_dout_nxt;
`ifdef RTC_BURST_EN
            r_rem         <= w_rem_nxt;
`endif
        end
    end

    assign io_dato    = r_drv ? r_dout : 8'hzz;
    assign o_wr_ack   = r_wr_ack;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_ad       = r_ad;
    assign o_cs       = r_cs;
    assign o_wr       = r_wr;
    assign o_rd       = r_rd;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl with a small RTC register-file model on the shared bus.
module tb_rtc_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [3:0] len = 4'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack, rd_valid, busy, done, ad, cs, wr, rd;
    logic [7:0] rd_data;
    wire  [7:0] dato;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rtc_bus_ctrl dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_rw       (rw),
        .i_addr     (addr),
        .i_len      (len),
        .i_wr_data  (wr_data),
        .o_wr_ack   (wr_ack),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_busy     (busy),
        .o_done     (done),
        .io_dato    (dato),
        .o_ad       (ad),
        .o_cs       (cs),
        .o_wr       (wr),
        .o_rd       (rd)
    );

    // Bus reads 0xFF whenever nobody drives it.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (dato[g]);
    end

    // RTC model: latches the address on an address strobe, stores/returns data in the data phase.
    logic [7:0] mem [256];
    logic [7:0] m_addr = 8'h00;
    logic       m_drv;
    assign m_drv = !cs && ad && !rd;
    assign dato  = m_drv ? mem[m_addr] : 8'hzz;

    always @(negedge clk) begin
        if (!cs && !ad && !wr) m_addr <= dato;
        if (!cs && ad && !wr)  mem[m_addr] <= dato;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int         r_done_cyc, r_done_cnt, r_ad_low, r_rd_low, r_wr_low, r_rdv, r_wack, r_both;
    logic [7:0] r_addr_q [$];

    // Issue one command and monitor the bus until a few cycles after done (bounded).
    task automatic run_cmd(input logic c_rw, input logic [7:0] c_addr, input logic [3:0] c_len,
                           input logic [7:0] c_wd, input int inj_cyc);
        logic prev_wr = 1'b1;
        r_done_cyc = 0; r_done_cnt = 0; r_ad_low = 0; r_rd_low = 0; r_wr_low = 0;
        r_rdv = 0; r_wack = 0; r_both = 0;
        r_addr_q.delete();
        @(negedge clk);
        start = 1'b1; rw = c_rw; addr = c_addr; len = c_len; wr_data = c_wd;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c == inj_cyc) begin
                start = 1'b1; addr = 8'h55; rw = 1'b0;
            end else if (c == inj_cyc + 1) begin
                start = 1'b0;
            end
            if (!ad) r_ad_low++;
            if (!rd) r_rd_low++;
            if (!wr) r_wr_low++;
            if (!wr && !rd) r_both++;
            if (rd_valid) r_rdv++;
            if (wr_ack) r_wack++;
            if (!ad && !wr && prev_wr) r_addr_q.push_back(dato);
            prev_wr = wr;
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc == 0) r_done_cyc = c;
            end
            if (r_done_cyc != 0 && c >= r_done_cyc + 4) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n_bad;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h45;
        mem[8'hFE] = 8'hA1;
        mem[8'hFF] = 8'hB2;
        mem[8'h00] = 8'hC3;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_pins", {28'd0, cs, wr, rd, ad}, 32'hF);
        check("rst_flags", {28'd0, busy, done, rd_valid, wr_ack}, 32'h0);
        check("rst_rd_data", rd_data, 32'h00);
        check("rst_dato_hiz", dato, 32'hFF);

        // single read
        run_cmd(1'b1, 8'h21, 4'd0, 8'h00, 0);
        check("rd_done_cyc", r_done_cyc, 29);
        check("rd_done_cnt", r_done_cnt, 1);
        check("rd_ad_low", r_ad_low, 12);
        check("rd_rd_low", r_rd_low, 8);
        check("rd_wr_low", r_wr_low, 8);
        check("rd_data", rd_data, 32'h45);
        check("rd_valid_cnt", r_rdv, 1);
        check("rd_addr", r_addr_q.size() > 0 ? r_addr_q[0] : 8'hEE, 32'h21);
        check("rd_no_overlap", r_both, 0);
        check("rd_idle_busy", busy, 0);

        // single write
        run_cmd(1'b0, 8'h22, 4'd0, 8'h13, 0);
        check("wr_done_cyc", r_done_cyc, 29);
        check("wr_mem", mem[8'h22], 32'h13);
        check("wr_ack_cnt", r_wack, 1);
        check("wr_rd_low", r_rd_low, 0);
        check("wr_wr_low", r_wr_low, 16);
        check("wr_rd_valid", r_rdv, 0);
        check("wr_rd_data_hold", rd_data, 32'h45);

`ifdef RTC_BURST_EN
        // burst read wrapping 0xFF -> 0x00
        run_cmd(1'b1, 8'hFE, 4'd2, 8'h00, 0);
        check("br_done_cyc", r_done_cyc, 93);
        check("br_rdv_cnt", r_rdv, 3);
        check("br_addr_cnt", r_addr_q.size(), 3);
        check("br_addr0", r_addr_q.size() > 0 ? r_addr_q[0] : 8'hEE, 32'hFE);
        check("br_addr1", r_addr_q.size() > 1 ? r_addr_q[1] : 8'hEE, 32'hFF);
        check("br_addr2", r_addr_q.size() > 2 ? r_addr_q[2] : 8'hEE, 32'h00);
        check("br_last_data", rd_data, 32'hC3);
        check("br_done_cnt", r_done_cnt, 1);
`else
        // len ignored without burst support
        run_cmd(1'b1, 8'hFE, 4'd3, 8'h00, 0);
        check("nb_done_cyc", r_done_cyc, 29);
        check("nb_rdv_cnt", r_rdv, 1);
        check("nb_addr_cnt", r_addr_q.size(), 1);
        check("nb_data", rd_data, 32'hA1);
`endif

        // start while busy is ignored
        run_cmd(1'b1, 8'h21, 4'd0, 8'h00, 10);
        check("ign_done_cyc", r_done_cyc, 29);
        check("ign_done_cnt", r_done_cnt, 1);
        check("ign_addr_cnt", r_addr_q.size(), 1);
        check("ign_addr", r_addr_q.size() > 0 ? r_addr_q[0] : 8'hEE, 32'h21);
        check("ign_rd_data", rd_data, 32'h45);
        check("ign_mem55", mem[8'h55], 32'h00);

        // reset during D_STROBE of a read
        mem[8'h21] = 8'h77;
        @(negedge clk);
        start = 1'b1; rw = 1'b1; addr = 8'h21; len = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 22; c++) begin
            @(posedge clk); #1;
        end
        check("rs_in_strobe", {30'd0, cs, rd}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rs_pins", {30'd0, cs, rd}, 32'h3);
        check("rs_dato_hiz", dato, 32'hFF);
        check("rs_flags", {29'd0, busy, rd_valid, done}, 32'h0);
        reset = 1'b0;
        n_bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (rd_valid || done || !cs) n_bad++;
        end
        check("rs_no_pulses", n_bad, 0);
        check("rs_rd_data", rd_data, 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
